regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (write_en/num/data) between ALU

---
 rtl/regfile_write_arbiter_if.sv | 39 +++
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback request, load-issue and register-file write bundle
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_AW     = 3
);
  localparam int NREG = 1 << REG_AW;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_AW-1:0]     alu_reg;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_AW-1:0]     mem_reg;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  load_issue;
  logic [REG_AW-1:0]     load_issue_reg;
  logic                  write_en;
  logic [REG_AW-1:0]     write_register_num;
  logic [DATA_WIDTH-1:0] write_register_in;
  logic                  write_src;
  logic [NREG-1:0]       reg_busy;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output load_issue, load_issue_reg,
    input  alu_ready, mem_ready,
    input  write_en, write_register_num, write_register_in, write_src, reg_busy
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  load_issue, load_issue_reg,
    output alu_ready, mem_ready,
    output write_en, write_register_num, write_register_in, write_src, reg_busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - ALU/MEM writeback arbiter with holding slots and load busy scoreboard
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int REG_AW       = 3,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);
  localparam int NREG = 1 << REG_AW;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic                  hold_alu_valid_q, hold_alu_valid_d;
  logic [REG_AW-1:0]     hold_alu_reg_q,   hold_alu_reg_d;
  logic [DATA_WIDTH-1:0] hold_alu_data_q,  hold_alu_data_d;
  logic                  hold_mem_valid_q, hold_mem_valid_d;
  logic [REG_AW-1:0]     hold_mem_reg_q,   hold_mem_reg_d;
  logic [DATA_WIDTH-1:0] hold_mem_data_q,  hold_mem_data_d;
  logic [2:0]            starve_q,         starve_d;
  logic                  write_en_q,       write_en_d;
  logic [REG_AW-1:0]     write_num_q,      write_num_d;
  logic [DATA_WIDTH-1:0] write_data_q,     write_data_d;
  logic                  write_src_q,      write_src_d;
  logic [NREG-1:0]       busy_q,           busy_d;

  logic grant_alu, grant_mem;
  logic alu_accept, mem_accept;

  // MEM wins contention until the ALU has lost LIMIT times in a row
  always_comb begin
    grant_mem = hold_mem_valid_q & (~hold_alu_valid_q | (starve_q != LIMIT));
    grant_alu = hold_alu_valid_q & ~grant_mem;
  end

  assign bus.alu_ready = ~rst & (~hold_alu_valid_q | grant_alu);
  assign bus.mem_ready = ~rst & (~hold_mem_valid_q | grant_mem);

  assign alu_accept = bus.alu_valid & bus.alu_ready;
  assign mem_accept = bus.mem_valid & bus.mem_ready;

  always_comb begin
    hold_alu_valid_d = hold_alu_valid_q;
    hold_alu_reg_d   = hold_alu_reg_q;
    hold_alu_data_d  = hold_alu_data_q;
    if (grant_alu) hold_alu_valid_d = 1'b0;
    if (alu_accept) begin
      hold_alu_valid_d = 1'b1;
      hold_alu_reg_d   = bus.alu_reg;
      hold_alu_data_d  = bus.alu_data;
    end

    hold_mem_valid_d = hold_mem_valid_q;
    hold_mem_reg_d   = hold_mem_reg_q;
    hold_mem_data_d  = hold_mem_data_q;
    if (grant_mem) hold_mem_valid_d = 1'b0;
    if (mem_accept) begin
      hold_mem_valid_d = 1'b1;
      hold_mem_reg_d   = bus.mem_reg;
      hold_mem_data_d  = bus.mem_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_alu || !hold_alu_valid_q) begin
      starve_d = 3'd0;
    end else if (grant_mem && (starve_q != LIMIT)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Without a grant the address/data keep their last values; only write_en drops
  always_comb begin
    write_en_d   = grant_alu | grant_mem;
    write_num_d  = write_num_q;
    write_data_d = write_data_q;
    write_src_d  = write_src_q;
    if (grant_mem) begin
      write_num_d  = hold_mem_reg_q;
      write_data_d = hold_mem_data_q;
      write_src_d  = 1'b1;
    end else if (grant_alu) begin
      write_num_d  = hold_alu_reg_q;
      write_data_d = hold_alu_data_q;
      write_src_d  = 1'b0;
    end
  end

  // Set after clear so a new load to the register being written stays outstanding
  always_comb begin
    busy_d = busy_q;
    if (grant_mem) busy_d[hold_mem_reg_q] = 1'b0;
    if (bus.load_issue && (bus.load_issue_reg != '0)) busy_d[bus.load_issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_alu_valid_q <= 1'b0;
      hold_alu_reg_q   <= '0;
      hold_alu_data_q  <= '0;
      hold_mem_valid_q <= 1'b0;
      hold_mem_reg_q   <= '0;
      hold_mem_data_q  <= '0;
      starve_q         <= 3'd0;
      write_en_q       <= 1'b0;
      write_num_q      <= '0;
      write_data_q     <= '0;
      write_src_q      <= 1'b0;
      busy_q           <= '0;
    end else begin
      hold_alu_valid_q <= hold_alu_valid_d;
      hold_alu_reg_q   <= hold_alu_reg_d;
      hold_alu_data_q  <= hold_alu_data_d;
      hold_mem_valid_q <= hold_mem_valid_d;
      hold_mem_reg_q   <= hold_mem_reg_d;
      hold_mem_data_q  <= hold_mem_data_d;
      starve_q         <= starve_d;
      write_en_q       <= write_en_d;
      write_num_q      <= write_num_d;
      write_data_q     <= write_data_d;
      write_src_q      <= write_src_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.write_en           = write_en_q;
  assign bus.write_register_num = write_num_q;
  assign bus.write_register_in  = write_data_q;
  assign bus.write_src          = write_src_q;
  assign bus.reg_busy           = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter against a queue-based model
module tb_regfile_write_arbiter;
  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int LIM = 3;
  localparam int NR  = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic          s;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .REG_AW(AW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .REG_AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each source owns a queue of at most one pending word
  wr_t exp_q[$];
  wr_t ha[$];
  wr_t hm[$];
  int  starve = 0;
  logic [NR-1:0] busy_m = '0;
  bit  alu_hold = 0;
  bit  mem_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick();
    if (ha.size() != 0 && hm.size() != 0) return (starve == LIM) ? 1 : 2;
    if (ha.size() != 0) return 1;
    if (hm.size() != 0) return 2;
    return 0;
  endfunction

  // Inputs are already on the bus; checks readies, then applies one clock edge to the model
  task automatic step();
    int g;
    bit ra, rm, a_empty, both;
    wr_t w;
    g = pick();
    ra = (ha.size() == 0) || (g == 1);
    rm = (hm.size() == 0) || (g == 2);
    #1;
    chk("alu_ready", 32'(bus.alu_ready), 32'(ra));
    chk("mem_ready", 32'(bus.mem_ready), 32'(rm));
    @(posedge clk);
    a_empty = (ha.size() == 0);
    both = (ha.size() != 0) && (hm.size() != 0);
    if (g == 1) begin
      w = ha.pop_front();
      exp_q.push_back(w);
    end else if (g == 2) begin
      w = hm.pop_front();
      exp_q.push_back(w);
      busy_m[w.r] = 1'b0;
    end
    if (g == 1 || a_empty) starve = 0;
    else if (both && g == 2 && starve < LIM) starve++;
    if (bus.alu_valid && ra) begin
      w.r = bus.alu_reg; w.d = bus.alu_data; w.s = 1'b0;
      ha.push_back(w);
    end
    if (bus.mem_valid && rm) begin
      w.r = bus.mem_reg; w.d = bus.mem_data; w.s = 1'b1;
      hm.push_back(w);
    end
    if (bus.load_issue && bus.load_issue_reg != '0) busy_m[bus.load_issue_reg] = 1'b1;
    alu_hold = bus.alu_valid && !ra;
    mem_hold = bus.mem_valid && !rm;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.load_issue = 0; bus.load_issue_reg = '0;
  endtask

  // Random cycle; pa/pm/pl are percent chances of ALU, MEM and load-issue activity
  task automatic rand_cycle(input int pa, input int pm, input int pl);
    @(negedge clk);
    if (!alu_hold) begin
      bus.alu_valid = ($urandom_range(99) < pa);
      bus.alu_reg   = AW'($urandom_range(NR-1));
      bus.alu_data  = DW'($urandom);
    end
    if (!mem_hold) begin
      bus.mem_valid = ($urandom_range(99) < pm);
      bus.mem_reg   = AW'($urandom_range(NR-1));
      bus.mem_data  = DW'($urandom);
    end
    bus.load_issue     = ($urandom_range(99) < pl);
    bus.load_issue_reg = AW'($urandom_range(NR-1));
    step();
  endtask

  task automatic set_cycle(input bit av, input int ar, input int ad,
                           input bit mv, input int mr, input int md,
                           input bit li, input int lr);
    @(negedge clk);
    bus.alu_valid = av; bus.alu_reg = AW'(ar); bus.alu_data = DW'(ad);
    bus.mem_valid = mv; bus.mem_reg = AW'(mr); bus.mem_data = DW'(md);
    bus.load_issue = li; bus.load_issue_reg = AW'(lr);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    idle_inputs();
    exp_q.delete(); ha.delete(); hm.delete();
    starve = 0; busy_m = '0; alu_hold = 0; mem_hold = 0;
    #1;
    chk("rst_write_en",  32'(bus.write_en), 0);
    chk("rst_num",       32'(bus.write_register_num), 0);
    chk("rst_data",      32'(bus.write_register_in), 0);
    chk("rst_src",       32'(bus.write_src), 0);
    chk("rst_busy",      32'(bus.reg_busy), 0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (bus.write_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 32'(bus.write_en), 0);
        end else begin
          e = exp_q.pop_front();
          chk("write_num",  32'(bus.write_register_num), 32'(e.r));
          chk("write_data", 32'(bus.write_register_in), 32'(e.d));
          chk("write_src",  32'(bus.write_src), 32'(e.s));
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_write", 32'(bus.write_en), 1);
        void'(exp_q.pop_front());
      end
      chk("reg_busy", 32'(bus.reg_busy), 32'(busy_m));
    end
  end

  initial begin
    idle_inputs();
    do_reset();

    // Single ALU write r3=0x1234
    set_cycle(1, 3, 'h1234, 0, 0, 0, 0, 0);
    set_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("single_alu_we", 32'(bus.write_en), 1);
    chk("single_alu_num", 32'(bus.write_register_num), 3);
    set_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("single_alu_we_low", 32'(bus.write_en), 0);

    // Scoreboard: set, clear on write, same-edge set wins
    set_cycle(0, 0, 0, 0, 0, 0, 1, 5);
    #1 chk("busy_r5_set", 32'(bus.reg_busy), 'h20);
    set_cycle(0, 0, 0, 1, 5, 'hbeef, 0, 0);
    set_cycle(0, 0, 0, 0, 0, 0, 1, 5);
    #1 chk("busy_r5_set_wins", 32'(bus.reg_busy), 'h20);
    set_cycle(0, 0, 0, 1, 5, 'h0042, 0, 0);
    set_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("busy_r5_cleared", 32'(bus.reg_busy), 0);

    // Register 0: never busy, writes pass through
    set_cycle(1, 0, 'hffff, 0, 0, 0, 1, 0);
    #1 chk("busy_r0", 32'(bus.reg_busy), 0);
    set_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_we", 32'(bus.write_en), 1);
    chk("r0_data", 32'(bus.write_register_in), 'hffff);

    // Back-to-back MEM words r1..r4
    for (int i = 1; i <= 4; i++) set_cycle(0, 0, 0, 1, i, 'h100 + i, 1, i + 1);
    for (int i = 0; i < 3; i++) set_cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Contention: both streams always valid -> M,M,M,A
    for (int i = 0; i < 24; i++) rand_cycle(100, 100, 20);

    // Reset with both slots full
    chk("slots_full_before_rst", 32'(ha.size() + hm.size()), 2);
    do_reset();
    for (int i = 0; i < 3; i++) set_cycle(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) rand_cycle(60, 60, 30);
    for (int i = 0; i < 200; i++) rand_cycle(90, 90, 50);
    @(negedge clk); idle_inputs(); step();
    for (int i = 0; i < 4; i++) set_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("drained", 32'(ha.size() + hm.size() + exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
